ppu_result_queue: RTL
=====================

// Module: ppu_result_queue
// PURPOSE
// - Output buffer stage directly downstream of posit normalization.
// - Takes the final N-bit posit word, with a valid/ready handshake, and
//   queues it in a DEPTH-entry in-order FIFO.
// - Presents results to the core writeback port from a registered output.
// - Back-pressure reaches the pipeline through ready_o.
// PARAMETERS
// - N      16  posit width in bits (>= 8)
// - DEPTH   4  queue entries; power of two, >= 2
// - CNT_W  16  width of the statistics counters (PPU_RESULT_STATS_EN only)
// PORTS
// - clk_i          in   1                  clock, all state updates on rising edge
// - rst_i          in   1                  synchronous reset, active-high
// - flush_i        in   1                  discard all queued results
// - posit_i        in   N                  result word from normalization
// - valid_i        in   1                  posit_i holds a result this cycle
// - ready_o        out  1                  queue can accept this cycle
// - posit_o        out  N                  head-of-queue result, registered
// - valid_o        out  1                  posit_o valid
// - ready_i        in   1                  writeback consumes posit_o
// - count_o        out  $clog2(DEPTH)+1    entries held, including the head
// - nar_cnt_o      out  CNT_W              NaR results accepted (stats build only)
// - zero_cnt_o     out  CNT_W              zero results accepted (stats build only)
// BEHAVIOUR
// - Reset (rst_i high at an edge):
//   - pointers and count_o = 0; valid_o = 0; posit_o = 0.
//   - ready_o = 1 from the first cycle after reset.
//   - Stats counters = 0.
//   - Reset mid-transfer drops every queued entry; nothing is replayed.
// - Push: a word is accepted on valid_i && ready_o.
// - Pop: the head is consumed on valid_o && ready_i.
// - ready_o = (count_o != DEPTH). It is purely a function of registered
//   count, with no combinational path from ready_i.
// - When full, a push in the same cycle as a pop is NOT accepted, because
//   ready_o is 0. Count drops to DEPTH-1 and ready_o rises next cycle.
// - Latency: a word pushed into an empty queue appears on posit_o with
//   valid_o = 1 exactly one cycle later. There is no combinational bypass.
// - Push and pop in the same cycle with 0 < count < DEPTH:
//   - count is unchanged;
//   - the next entry moves to posit_o on the next cycle;
//   - order is preserved.
// - While valid_o = 1 and ready_i = 0:
//   - posit_o and valid_o hold stable;
//   - the accepted word is never overwritten.
// - When valid_o = 0, posit_o holds its last value. The consumer must ignore it.
// - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count_o never
//   exceeds DEPTH and never underflows.
// - flush_i:
//   - next cycle count_o = 0 and valid_o = 0;
//   - flush has priority over a push or pop in the same cycle; that push is
//     dropped, even though ready_o was 1;
//   - stats counters are not cleared.
// - rst_i has priority over flush_i.
// - Payload is opaque. The queue never alters posit_i bits.
// CONFIGURATION
// - Macro PPU_RESULT_STATS_EN defined:
//   - per accepted push, nar_cnt_o += 1 if posit_i == {1'b1,{N-1{1'b0}}};
//   - zero_cnt_o += 1 if posit_i == 0;
//   - both counters saturate at all-ones and never wrap;
//   - a push dropped by flush_i is not counted.
// - Macro not defined: nar_cnt_o and zero_cnt_o are tied to 0 and no
//   counter flops are built.
// TESTING
// - Single result: push 16'h4000 into an empty queue, ready_i = 1
//   -> valid_o = 1 and posit_o = 16'h4000 one cycle later; count_o back to 0
//   the cycle after.
// - Fill: ready_i = 0, push 16'h0001..16'h0004
//   -> count_o = 4 and ready_o = 0; a 5th valid_i is ignored.
//   - Then ready_i = 1 -> outputs in order 1, 2, 3, 4, one per cycle.
// - Full with push and pop in the same cycle: count = 4, valid_i = 1,
//   ready_i = 1 -> push not taken; count_o = 3 and ready_o = 1 next cycle.
// - Stall hold: valid_o = 1, posit_o = 16'h7FFF, ready_i = 0 for 5 cycles
//   -> posit_o stable and no entry lost.
// - Flush: count = 3 plus a simultaneous push -> count_o = 0 and valid_o = 0
//   next cycle; the pushed word never appears.
// - Stats (PPU_RESULT_STATS_EN): push 16'h8000 x3 and 16'h0000 x2
//   -> nar_cnt_o = 3 and zero_cnt_o = 2.
//   - Reset -> both counters 0.

Source files
------------

// File: rtl/ppu_result_queue.sv
// ppu_result_queue
//   In-order result FIFO between posit normalization and core writeback.
//   The head of the queue is held in a dedicated output register. A word
//   pushed into an empty queue is loaded into that register directly, so it
//   is visible one cycle after acceptance with no combinational path from
//   posit_i to posit_o.
//
// Optional feature macro: PPU_RESULT_STATS_EN
//   defined   -> saturating counters of accepted NaR and zero results
//   undefined -> nar_cnt_o / zero_cnt_o tied to 0, no counter flops
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active-high (priority over flush_i)
//   flush_i     discard all queued results (priority over push/pop)
//   posit_i     N-bit result word from normalization
//   valid_i     posit_i valid this cycle
//   ready_o     queue can accept (registered, count_o != DEPTH)
//   posit_o     head-of-queue result (registered)
//   valid_o     posit_o valid (registered)
//   ready_i     writeback consumes posit_o
//   count_o     entries held, head included
//   nar_cnt_o   accepted NaR results (stats build only)
//   zero_cnt_o  accepted zero results (stats build only)

module ppu_result_queue #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [N-1:0]                 posit_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [N-1:0]                 posit_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [CNT_W-1:0]             nar_cnt_o,
    output logic [CNT_W-1:0]             zero_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_OW = PTR_W + 1;

    // Storage holds every queued entry, head included; posit_q mirrors the head.
    logic [N-1:0]      mem_q [DEPTH];
    logic [N-1:0]      mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_OW-1:0] count_q, count_d;
    logic [N-1:0]      posit_q, posit_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              push;
    logic              pop;
    logic [CNT_OW-1:0] remain;

    // Next-state for pointers, count, head register and ready.
    always_comb begin
        push     = valid_i && ready_q;
        pop      = valid_q && ready_i;
        remain   = count_q - CNT_OW'(pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        posit_d  = posit_q;
        valid_d  = valid_q;
        ready_d  = ready_q;

        if (flush_i) begin
            // posit_q is left as is; valid_o low marks it stale.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            ready_d  = 1'b1;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = posit_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_OW'(push) - CNT_OW'(pop);
            valid_d = (count_d != '0);
            ready_d = (count_d != CNT_OW'(DEPTH));
            // Reload the head register when the head changes. If nothing
            // else is left after the pop, the new head is the word being
            // pushed this cycle, which is not in mem_q yet.
            if ((count_d != '0) && (pop || (count_q == '0))) begin
                posit_d = (remain == '0) ? posit_i : mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            posit_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            posit_q  <= posit_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    // Payload storage; contents are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign ready_o = ready_q;
    assign posit_o = posit_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

`ifdef PPU_RESULT_STATS_EN
    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    logic [CNT_W-1:0] nar_cnt_q, nar_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

    // Saturating counters over accepted pushes; a push lost to flush is not counted.
    always_comb begin
        nar_cnt_d  = nar_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (push && !flush_i) begin
            if ((posit_i == NAR_WORD) && (nar_cnt_q != '1)) begin
                nar_cnt_d = nar_cnt_q + CNT_W'(1);
            end
            if ((posit_i == '0) && (zero_cnt_q != '1)) begin
                zero_cnt_d = zero_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counters clear only on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nar_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else begin
            nar_cnt_q  <= nar_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign nar_cnt_o  = nar_cnt_q;
    assign zero_cnt_o = zero_cnt_q;
`else
    assign nar_cnt_o  = '0;
    assign zero_cnt_o = '0;
`endif

endmodule
